// File: rtl/ddr3_avl_arbiter.sv
`default_nettype none
// ============================================================================
// ddr3_avl_arbiter : reader/writer arbiter for the DDR3 Avalon-MM port.
// Optional macro ARB_PERF_COUNT_EN adds saturating performance counters.
// Revision: 1.0
// ============================================================================
module ddr3_avl_arbiter #(
  parameter int ADDR_WIDTH      = 26,
  parameter int DATA_WIDTH      = 128,
  parameter int BURST_WIDTH     = 3,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_req,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [BURST_WIDTH-1:0] rd_size,
  input  logic                   rd_urgent,
  output logic                   rd_ack,
  output logic                   rd_data_valid,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   wr_req,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [BURST_WIDTH-1:0] wr_size,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_data_ack,
  output logic                   wr_done,
  input  logic                   ddr3_avl_ready,
  output logic                   ddr3_avl_burstbegin,
  output logic [BURST_WIDTH-1:0] ddr3_avl_size,
  output logic                   ddr3_avl_read_req,
  output logic                   ddr3_avl_write_req,
  output logic [DATA_WIDTH-1:0]  ddr3_avl_wr_data,
  output logic [ADDR_WIDTH-1:0]  ddr3_avl_addr,
  input  logic                   ddr3_avl_read_data_valid,
  input  logic [DATA_WIDTH-1:0]  ddr3_avl_read_data
`ifdef ARB_PERF_COUNT_EN
  ,
  input  logic                   perf_clear,
  output logic [31:0]            perf_rd_bursts,
  output logic [31:0]            perf_wr_bursts,
  output logic [31:0]            perf_stall_cycles
`endif
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t                 state, next_state;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BURST_WIDTH-1:0] cmd_size;
  logic [BURST_WIDTH-1:0] beat_cnt;
  logic                   first_beat;
  logic [CNT_W-1:0]       outstanding;
  logic [STARVE_W-1:0]    starve_cnt;
  logic                   last_grant;  // 1 = reader won the previous grant

  logic [BURST_WIDTH-1:0] rd_size_eff, wr_size_eff;
  logic                   rd_eligible, starve_hit, grant_rd, grant_wr;
  logic                   rd_cmd_acc, wr_beat_acc, last_beat;
  logic [CNT_W-1:0]       out_inc, out_dec;

  assign rd_size_eff = (rd_size == '0) ? BURST_WIDTH'(1) : rd_size;
  assign wr_size_eff = (wr_size == '0) ? BURST_WIDTH'(1) : wr_size;
  assign rd_eligible = rd_req &&
                       ((32'(outstanding) + 32'(rd_size_eff)) <= 32'(MAX_OUTSTANDING));
  assign starve_hit  = 32'(starve_cnt) >= 32'(STARVE_LIMIT);

  assign rd_cmd_acc  = (state == RD_CMD) && ddr3_avl_ready;
  assign wr_beat_acc = (state == WR_BURST) && ddr3_avl_ready;
  assign last_beat   = (beat_cnt == (cmd_size - BURST_WIDTH'(1)));

  assign ddr3_avl_read_req   = (state == RD_CMD);
  assign ddr3_avl_write_req  = (state == WR_BURST);
  assign ddr3_avl_burstbegin = (state == RD_CMD) || ((state == WR_BURST) && first_beat);
  assign ddr3_avl_addr       = cmd_addr;
  assign ddr3_avl_size       = cmd_size;
  assign ddr3_avl_wr_data    = wr_data;
  assign rd_ack              = rd_cmd_acc;
  assign wr_data_ack         = wr_beat_acc;
  // Beats with nothing outstanding (e.g. stale returns after reset) are dropped.
  assign rd_data_valid       = ddr3_avl_read_data_valid && (outstanding != '0);
  assign rd_data             = ddr3_avl_read_data;

  assign out_inc = rd_cmd_acc ? CNT_W'(cmd_size) : '0;
  assign out_dec = CNT_W'(rd_data_valid);

  always_comb begin
    next_state = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && starve_hit)        grant_wr = 1'b1;
        else if (rd_eligible && rd_urgent) grant_rd = 1'b1;
        else if (rd_eligible && wr_req) begin
          if (last_grant) grant_wr = 1'b1;
          else            grant_rd = 1'b1;
        end
        else if (rd_eligible)            grant_rd = 1'b1;
        else if (wr_req)                 grant_wr = 1'b1;
        if (grant_rd)      next_state = RD_CMD;
        else if (grant_wr) next_state = WR_BURST;
      end
      RD_CMD:   if (ddr3_avl_ready) next_state = IDLE;
      WR_BURST: if (ddr3_avl_ready && last_beat) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_addr    <= '0;
      cmd_size    <= '0;
      beat_cnt    <= '0;
      first_beat  <= 1'b0;
      outstanding <= '0;
      starve_cnt  <= '0;
      last_grant  <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      state       <= next_state;
      wr_done     <= wr_beat_acc && last_beat;
      outstanding <= outstanding + out_inc - out_dec;
      if (grant_rd) begin
        cmd_addr   <= rd_addr;
        cmd_size   <= rd_size_eff;
        last_grant <= 1'b1;
        if (wr_req) starve_cnt <= starve_cnt + STARVE_W'(1);
      end
      if (grant_wr) begin
        cmd_addr   <= wr_addr;
        cmd_size   <= wr_size_eff;
        last_grant <= 1'b0;
        starve_cnt <= '0;
        first_beat <= 1'b1;
        beat_cnt   <= '0;
      end
      if (wr_beat_acc) begin
        first_beat <= 1'b0;
        beat_cnt   <= beat_cnt + BURST_WIDTH'(1);
      end
    end
  end

`ifdef ARB_PERF_COUNT_EN
  logic stall;
  assign stall = (ddr3_avl_read_req || ddr3_avl_write_req) && !ddr3_avl_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rd_bursts    <= '0;
      perf_wr_bursts    <= '0;
      perf_stall_cycles <= '0;
    end else if (perf_clear) begin
      perf_rd_bursts    <= '0;
      perf_wr_bursts    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_cmd_acc && (perf_rd_bursts != '1))
        perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if (wr_beat_acc && last_beat && (perf_wr_bursts != '1))
        perf_wr_bursts <= perf_wr_bursts + 32'd1;
      if (stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_avl_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ddr3_avl_arbiter : scenario tasks with queue scoreboards for the arbiter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ddr3_avl_arbiter;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int BW = 3;

  logic          clk;
  logic          reset;
  logic          rd_req, rd_urgent, rd_ack, rd_data_valid;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_size;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_data_ack, wr_done;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_size;
  logic [DW-1:0] wr_data;
  logic          ddr3_avl_ready, ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req;
  logic [BW-1:0] ddr3_avl_size;
  logic [DW-1:0] ddr3_avl_wr_data;
  logic [AW-1:0] ddr3_avl_addr;
  logic          ddr3_avl_read_data_valid;
  logic [DW-1:0] ddr3_avl_read_data;
`ifdef ARB_PERF_COUNT_EN
  logic          perf_clear;
  logic [31:0]   perf_rd_bursts, perf_wr_bursts, perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] exp_wr_q[$];

  ddr3_avl_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_urgent(rd_urgent),
    .rd_ack(rd_ack), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .wr_data_ack(wr_data_ack), .wr_done(wr_done),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_read_req(ddr3_avl_read_req),
    .ddr3_avl_write_req(ddr3_avl_write_req), .ddr3_avl_wr_data(ddr3_avl_wr_data),
    .ddr3_avl_addr(ddr3_avl_addr), .ddr3_avl_read_data_valid(ddr3_avl_read_data_valid),
    .ddr3_avl_read_data(ddr3_avl_read_data)
`ifdef ARB_PERF_COUNT_EN
    , .perf_clear(perf_clear), .perf_rd_bursts(perf_rd_bursts),
    .perf_wr_bursts(perf_wr_bursts), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat_word(input logic [31:0] tag, input int i);
    return {4{tag + 32'(i)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_req = 0; rd_addr = '0; rd_size = '0; rd_urgent = 0;
    wr_req = 0; wr_addr = '0; wr_size = '0; wr_data = '0;
    ddr3_avl_ready = 1; ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = pat_word(32'hDEAD0000, 0);
    repeat (2) step();
    @(negedge clk);
    total++;
    if ({ddr3_avl_read_req, ddr3_avl_write_req, ddr3_avl_burstbegin, rd_ack, wr_data_ack, wr_done, rd_data_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rq=%b wq=%b bb=%b rack=%b wack=%b done=%b rv=%b, want all 0",
               ddr3_avl_read_req, ddr3_avl_write_req, ddr3_avl_burstbegin, rd_ack, wr_data_ack, wr_done, rd_data_valid);
    end
    total++;
    if (ddr3_avl_addr !== '0 || ddr3_avl_size !== '0) begin
      bad++;
      $display("FAIL reset_cmd: addr=%h size=%0d, want 0/0", ddr3_avl_addr, ddr3_avl_size);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_stray_valid: rd_data_valid=%b, want 0", rd_data_valid);
    end
    step();
    ddr3_avl_read_data_valid = 0;
  endtask

  task automatic test_single_read();
    int rdq, acks;
    logic [DW-1:0] v;
    rd_addr = 26'h100; rd_size = 3'd4; rd_urgent = 0; rd_req = 1; ddr3_avl_ready = 1;
    rdq = 0; acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ddr3_avl_read_req) begin
        rdq++;
        total++;
        if (ddr3_avl_addr !== 26'h100 || ddr3_avl_size !== 3'd4 || ddr3_avl_burstbegin !== 1'b1) begin
          bad++;
          $display("FAIL single_read_cmd: addr=%h size=%0d bb=%b, want 100/4/1",
                   ddr3_avl_addr, ddr3_avl_size, ddr3_avl_burstbegin);
        end
      end
      if (rd_ack) begin acks++; rd_req = 0; end
      step();
    end
    total++;
    if (rdq != 1 || acks != 1) begin
      bad++;
      $display("FAIL single_read_pulse: read_req cycles=%0d acks=%0d, want 1/1", rdq, acks);
    end
    total++;
    if (dut.outstanding !== 4) begin
      bad++;
      $display("FAIL single_read_outstanding: got %0d want 4", dut.outstanding);
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd_q.push_back(pat_word(32'hA0000000, i));
      ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = pat_word(32'hA0000000, i);
      @(negedge clk);
      v = exp_rd_q.pop_front();
      total++;
      if (rd_data_valid !== 1'b1 || rd_data !== v) begin
        bad++;
        $display("FAIL single_read_beat%0d: valid=%b data=%h want 1/%h", i, rd_data_valid, rd_data, v);
      end
      step();
    end
    ddr3_avl_read_data_valid = 0;
    total++;
    if (dut.outstanding !== 0) begin
      bad++;
      $display("FAIL single_read_drain: outstanding=%0d want 0", dut.outstanding);
    end
  endtask

  task automatic test_outstanding_limit();
    int rdq, acks;
    logic [DW-1:0] v;
    rd_addr = 26'h300; rd_size = 3'd5; rd_req = 1; ddr3_avl_ready = 1; acks = 0;
    for (int c = 0; c < 8 && acks == 0; c++) begin
      @(negedge clk);
      if (rd_ack) begin acks++; rd_req = 0; end
      step();
    end
    total++;
    if (acks != 1 || dut.outstanding !== 5) begin
      bad++;
      $display("FAIL limit_first: acks=%0d outstanding=%0d want 1/5", acks, dut.outstanding);
    end
    rd_addr = 26'h308; rd_req = 1; rdq = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ddr3_avl_read_req) rdq++;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      exp_rd_q.push_back(pat_word(32'hB0000000, i));
      ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = pat_word(32'hB0000000, i);
      @(negedge clk);
      if (ddr3_avl_read_req) rdq++;
      v = exp_rd_q.pop_front();
      total++;
      if (rd_data_valid !== 1'b1 || rd_data !== v) begin
        bad++;
        $display("FAIL limit_beat%0d: valid=%b data=%h want 1/%h", i, rd_data_valid, rd_data, v);
      end
      step();
    end
    ddr3_avl_read_data_valid = 0;
    total++;
    if (rdq != 0) begin
      bad++;
      $display("FAIL limit_blocked: second read issued %0d cycles early, want 0", rdq);
    end
    acks = 0;
    for (int c = 0; c < 6 && acks == 0; c++) begin
      @(negedge clk);
      if (ddr3_avl_read_req && rd_ack) begin
        acks++; rd_req = 0;
        total++;
        if (ddr3_avl_addr !== 26'h308 || ddr3_avl_size !== 3'd5) begin
          bad++;
          $display("FAIL limit_second_cmd: addr=%h size=%0d want 308/5", ddr3_avl_addr, ddr3_avl_size);
        end
      end
      step();
    end
    total++;
    if (acks != 1 || dut.outstanding !== 8) begin
      bad++;
      $display("FAIL limit_second: acks=%0d outstanding=%0d want 1/8", acks, dut.outstanding);
    end
    for (int i = 0; i < 8; i++) begin
      exp_rd_q.push_back(pat_word(32'hB1000000, i));
      ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = pat_word(32'hB1000000, i);
      @(negedge clk);
      v = exp_rd_q.pop_front();
      total++;
      if (rd_data_valid !== 1'b1 || rd_data !== v) begin
        bad++;
        $display("FAIL limit_drain%0d: valid=%b data=%h want 1/%h", i, rd_data_valid, rd_data, v);
      end
      step();
    end
    ddr3_avl_read_data_valid = 0;
  endtask

  task automatic test_write_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int k, acks, bb_cnt, bb_cyc, wreq_cnt, last_ack_c, done_c, done_cnt, addr_bad;
    logic [DW-1:0] v;
    k = 0; acks = 0; bb_cnt = 0; bb_cyc = -1; wreq_cnt = 0;
    last_ack_c = -10; done_c = -1; done_cnt = 0; addr_bad = 0;
    for (int i = 0; i < 3; i++) exp_wr_q.push_back(pat_word(32'hC0000000, i));
    wr_addr = 26'h200; wr_size = 3'd3; wr_data = pat_word(32'hC0000000, 0); wr_req = 1;
    for (int c = 0; c < 12; c++) begin
      if (ddr3_avl_write_req) begin
        ddr3_avl_ready = (k < 4) ? pat[k] : 1'b1;
        k++;
      end else ddr3_avl_ready = 1'b1;
      @(negedge clk);
      if (ddr3_avl_write_req) begin
        wreq_cnt++;
        if (ddr3_avl_burstbegin) begin bb_cnt++; bb_cyc = wreq_cnt; end
        if (ddr3_avl_addr !== 26'h200 || ddr3_avl_size !== 3'd3) addr_bad++;
      end
      if (wr_data_ack) begin
        v = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '0;
        total++;
        if (ddr3_avl_wr_data !== v) begin
          bad++;
          $display("FAIL wr_beat%0d: data=%h want %h", acks, ddr3_avl_wr_data, v);
        end
        acks++; last_ack_c = c; wr_req = 0;
      end
      if (wr_done) begin done_cnt++; done_c = c; end
      step();
      wr_data = pat_word(32'hC0000000, acks);
    end
    ddr3_avl_ready = 1;
    total++;
    if (wreq_cnt != 4 || acks != 3) begin
      bad++;
      $display("FAIL wr_cycles: write_req cycles=%0d acks=%0d want 4/3", wreq_cnt, acks);
    end
    total++;
    if (bb_cnt != 1 || bb_cyc != 1) begin
      bad++;
      $display("FAIL wr_burstbegin: count=%0d at cycle %0d want 1 at 1", bb_cnt, bb_cyc);
    end
    total++;
    if (done_cnt != 1 || done_c != last_ack_c + 1) begin
      bad++;
      $display("FAIL wr_done: count=%0d cycle=%0d want 1 at %0d", done_cnt, done_c, last_ack_c + 1);
    end
    total++;
    if (addr_bad != 0) begin
      bad++;
      $display("FAIL wr_cmd: %0d cycles with addr/size not 200/3", addr_bad);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_w = 9'b100001010;  // index 0 first: R W R W R R R R W
    int n;
    n = 0;
    rd_addr = 26'h400; rd_size = 3'd1; wr_addr = 26'h500; wr_size = 3'd1;
    wr_data = pat_word(32'hE0000000, 0);
    rd_urgent = 0; ddr3_avl_ready = 1; rd_req = 1; wr_req = 1;
    for (int c = 0; c < 40 && n < 9; c++) begin
      @(negedge clk);
      if (ddr3_avl_read_req && rd_ack) begin
        total++;
        if (exp_w[n] !== 1'b0) begin
          bad++;
          $display("FAIL rr_grant%0d: got R want W", n);
        end
        n++;
      end else if (ddr3_avl_write_req && ddr3_avl_burstbegin && wr_data_ack) begin
        total++;
        if (exp_w[n] !== 1'b1) begin
          bad++;
          $display("FAIL rr_grant%0d: got W want R", n);
        end
        n++;
      end
      if (n >= 4) rd_urgent = 1;
      if (n >= 9) begin rd_req = 0; wr_req = 0; end
      step();
    end
    rd_req = 0; wr_req = 0; rd_urgent = 0;
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL rr_grant_count: got %0d want 9", n);
    end
    ddr3_avl_read_data_valid = 1;
    repeat (6) step();
    ddr3_avl_read_data_valid = 0;
    total++;
    if (dut.outstanding !== 0) begin
      bad++;
      $display("FAIL rr_drain: outstanding=%0d want 0", dut.outstanding);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acks, done_cnt, wreq;
    acks = 0;
    wr_addr = 26'h600; wr_size = 3'd6; wr_data = pat_word(32'hF0000000, 0); wr_req = 1; ddr3_avl_ready = 1;
    for (int c = 0; c < 10 && acks < 1; c++) begin
      @(negedge clk);
      if (wr_data_ack) begin acks++; wr_req = 0; end
      step();
    end
    total++;
    if (ddr3_avl_write_req !== 1'b1 || acks != 1) begin
      bad++;
      $display("FAIL midburst_active: write_req=%b acks=%0d want 1/1", ddr3_avl_write_req, acks);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ddr3_avl_read_req, ddr3_avl_write_req, ddr3_avl_burstbegin, wr_data_ack, rd_ack, wr_done} !== 6'b0
        || ddr3_avl_addr !== '0 || ddr3_avl_size !== '0) begin
      bad++;
      $display("FAIL midburst_reset_outputs: wq=%b bb=%b wack=%b addr=%h size=%0d want all 0",
               ddr3_avl_write_req, ddr3_avl_burstbegin, wr_data_ack, ddr3_avl_addr, ddr3_avl_size);
    end
    step(); step();
    reset = 1'b0;
    done_cnt = 0; wreq = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_done) done_cnt++;
      if (ddr3_avl_write_req) wreq++;
      step();
    end
    total++;
    if (done_cnt != 0 || wreq != 0) begin
      bad++;
      $display("FAIL midburst_after: wr_done=%0d write_req=%0d want 0/0", done_cnt, wreq);
    end
    ddr3_avl_read_data_valid = 1;
    @(negedge clk);
    total++;
    if (rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL midburst_stray_valid: rd_data_valid=%b want 0", rd_data_valid);
    end
    step();
    ddr3_avl_read_data_valid = 0;
  endtask

`ifdef ARB_PERF_COUNT_EN
  task automatic test_perf();
    int stalls [5] = '{2, 1, 0, 2, 0};
    int low;
    bit done;
    perf_clear = 1; step(); perf_clear = 0;
    for (int op = 0; op < 5; op++) begin
      if (op < 3) begin rd_addr = 26'h700 + 26'(op); rd_size = 3'd1; rd_req = 1; end
      else begin wr_addr = 26'h780 + 26'(op); wr_size = 3'd1; wr_req = 1; end
      low = 0; done = 0; ddr3_avl_ready = 0;
      for (int c = 0; c < 12 && !done; c++) begin
        if (ddr3_avl_read_req || ddr3_avl_write_req) begin
          if (low < stalls[op]) begin ddr3_avl_ready = 0; low++; end
          else ddr3_avl_ready = 1;
        end else ddr3_avl_ready = 0;
        @(negedge clk);
        if (rd_ack || wr_data_ack) begin done = 1; rd_req = 0; wr_req = 0; end
        step();
      end
    end
    ddr3_avl_ready = 1;
    step(); step();
    total++;
    if (perf_rd_bursts !== 32'd3 || perf_wr_bursts !== 32'd2 || perf_stall_cycles !== 32'd5) begin
      bad++;
      $display("FAIL perf_counts: rd=%0d wr=%0d stall=%0d want 3/2/5",
               perf_rd_bursts, perf_wr_bursts, perf_stall_cycles);
    end
    perf_clear = 1; step(); perf_clear = 0;
    @(negedge clk);
    total++;
    if (perf_rd_bursts !== 0 || perf_wr_bursts !== 0 || perf_stall_cycles !== 0) begin
      bad++;
      $display("FAIL perf_clear: rd=%0d wr=%0d stall=%0d want 0/0/0",
               perf_rd_bursts, perf_wr_bursts, perf_stall_cycles);
    end
    step();
  endtask
`endif

  initial begin
`ifdef ARB_PERF_COUNT_EN
    perf_clear = 0;
`endif
    test_reset();
    test_single_read();
    test_outstanding_limit();
    test_write_backpressure();
    test_round_robin();
    test_reset_mid_burst();
`ifdef ARB_PERF_COUNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ddr3_avl_arbiter.md
Name: ddr3_avl_arbiter

Overview:
- Shares the single DDR3 Avalon-MM port of ddr3_top between two requesters:
  - the VGA frame-fetch reader, read-only;
  - the frame writer fed from the CSR path, write-only.
- Sequences burst commands and tracks outstanding read beats so the controller read queue never overflows.
- Prioritises the reader when its pixel FIFO is running low, with starvation protection for the writer.

Parameters:
- ADDR_WIDTH, 26, Avalon word address width.
- DATA_WIDTH, 128, Avalon data width.
- BURST_WIDTH, 3, width of the size fields; legal sizes are 1..7.
- MAX_OUTSTANDING, 8, maximum read beats in flight.
- STARVE_LIMIT, 4, consecutive read grants allowed while a write is waiting.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- rd_req  in  1  reader command request; held until rd_ack.
- rd_addr  in  ADDR_WIDTH  read burst start address.
- rd_size  in  BURST_WIDTH  read burst beats.
- rd_urgent  in  1  reader FIFO below low-water mark.
- rd_ack  out  1  one-cycle pulse when the read command is accepted by DDR3.
- rd_data_valid  out  1  returned read beat valid.
- rd_data  out  DATA_WIDTH  returned read beat.
- wr_req  in  1  writer burst request; held until the first beat is accepted.
- wr_addr  in  ADDR_WIDTH  write burst start address.
- wr_size  in  BURST_WIDTH  write burst beats.
- wr_data  in  DATA_WIDTH  current write beat.
- wr_data_ack  out  1  current beat consumed; the writer presents the next beat in the following cycle.
- wr_done  out  1  one-cycle pulse after the last beat is accepted.
- ddr3_avl_ready  in  1  controller ready.
- ddr3_avl_burstbegin  out  1  first cycle of each command.
- ddr3_avl_size  out  BURST_WIDTH  burst size.
- ddr3_avl_read_req  out  1  read command.
- ddr3_avl_write_req  out  1  write beat.
- ddr3_avl_wr_data  out  DATA_WIDTH  equals wr_data (combinational).
- ddr3_avl_addr  out  ADDR_WIDTH  burst address.
- ddr3_avl_read_data_valid  in  1  read beat returned.
- ddr3_avl_read_data  in  DATA_WIDTH  read data.

Behaviour:
- Reset state: state IDLE; outstanding count, starve count, last_grant and all registered outputs 0. Reset mid-burst abandons the burst; no wr_done is issued.
- States: IDLE, RD_CMD, WR_BURST.
- IDLE arbitration, evaluated every cycle, with the winner registered into the command outputs on the next cycle:
  - A read is eligible when rd_req=1 and outstanding + rd_size <= MAX_OUTSTANDING.
  - Write wins if wr_req=1 and starve count >= STARVE_LIMIT, even over rd_urgent.
  - Otherwise read wins if it is eligible and rd_urgent=1.
  - Otherwise, when both are eligible, round-robin against last_grant.
  - Otherwise the single eligible requester wins.
- A read grant increments starve count while wr_req=1. A write grant clears starve count.
- RD_CMD:
  - Drives read_req=1, burstbegin=1, addr/size latched from the requester.
  - Holds until ddr3_avl_ready=1. In that cycle: rd_ack=1, outstanding += size, return to IDLE.
  - Result: 1 cycle of idle arbitration plus at least 1 command cycle.
- WR_BURST:
  - Latches addr and size.
  - write_req=1 each cycle; burstbegin=1 only until the first beat is accepted.
  - wr_data_ack = write_req & ddr3_avl_ready.
  - A beat counter advances on each accepted beat. On the final accepted beat: wr_done=1 next cycle, return to IDLE.
- Read return:
  - rd_data_valid/rd_data pass ddr3_avl_read_data_valid/data through combinationally. Each valid decrements outstanding.
  - A return and a new read acceptance in the same cycle give outstanding += size - 1.
  - A valid arriving while outstanding=0 (e.g. after reset) is dropped: rd_data_valid gated to 0.
- Size 0 on either requester is treated as 1.
- Addresses and sizes are sampled only at grant; changes afterwards are ignored until the next grant.

Optional Feature:
- Macro ARB_PERF_COUNT_EN.
- When defined, adds:
  - input perf_clear;
  - outputs perf_rd_bursts[31:0], perf_wr_bursts[31:0], perf_stall_cycles[31:0].
- Counters: accepted read commands, completed write bursts, and cycles with a command asserted while ddr3_avl_ready=0.
- Counters are saturating, cleared by reset or perf_clear, with clear taking priority over increment.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single read: rd_req, addr 0x100, size 4, ready=1 → read_req and burstbegin for 1 cycle with addr 0x100, size 4; rd_ack pulse; outstanding=4; 4 returned beats reach rd_data; outstanding=0.
- Write burst with backpressure: wr_size 3, ready toggling 1,0,1,1 → write_req for 4 cycles; burstbegin only on cycle 1; exactly 3 wr_data_ack; wr_done one cycle after the third accepted beat.
- Outstanding limit: two reads of size 5 with no data returned → second blocked; after 2 beats return (outstanding=3), second issues; outstanding=8.
- Round-robin and urgency: both requesting continuously, rd_urgent=0 → grants alternate R,W,R,W. With rd_urgent=1 → 4 reads, then 1 write forced by STARVE_LIMIT=4.
- Reset mid-burst: assert reset during beat 2 of a 6-beat write → outputs 0 immediately; no wr_done; a stray read valid after reset gives rd_data_valid=0.
- With ARB_PERF_COUNT_EN: 3 reads and 2 writes with 5 ready-low cycles → counters 3/2/5; perf_clear → all 0.
